timing_seq: RTL

TIMING_SEQ -- requirements
Module: timing_seq

---
 rtl/timing_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/timing_seq.sv
// Machine-cycle beat sequencer: emits one-hot W1/W2/W3 beats on falling T3 edges.
// Optional single-cycle stepping is compiled in with `define TIMING_SEQ_STEP_EN.
module timing_seq (
  input  logic       T3,
  input  logic       CLR,
  input  logic       START,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
  input  logic       STEP,
  output logic [3:1] W,
  output logic       RUN,
  output logic       CYC_END,
  output logic [7:0] CYC_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [3:1] r_w;
  logic [3:1] w_w_nx;
  logic       r_start_q;
  logic [7:0] r_cyc_cnt;
  logic       w_start_edge;
  logic       w_cyc_end;
  logic       w_halt_req;

  assign w_start_edge = START & ~r_start_q;

  // SHORT only matters in W1 and LONG only in W2, so SHORT wins when both are high in W1.
  assign w_cyc_end = (r_w[1] & SHORT) | (r_w[2] & ~LONG) | r_w[3];

`ifdef TIMING_SEQ_STEP_EN
  assign w_halt_req = STOP | STEP;
`else
  logic w_unused_step;
  assign w_unused_step = STEP;
  assign w_halt_req    = STOP;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_nx = r_state;
    w_w_nx     = r_w;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (w_start_edge) begin
          w_state_nx = ST_RUN;
          w_w_nx     = 3'b001;
        end
      end
      ST_RUN: begin
        if (w_cyc_end) begin
          if (w_halt_req) begin
            w_state_nx = ST_HALT;
            w_w_nx     = 3'b000;
          end else begin
            w_w_nx = 3'b001;
          end
        end else if (r_w[1]) begin
          w_w_nx = 3'b010;
        end else if (r_w[2]) begin
          w_w_nx = 3'b100;
        end else begin
          w_w_nx = 3'b001;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_w_nx     = 3'b000;
      end
    endcase
  end

  // START history resets to 1 so a START held through CLR is not seen as an edge.
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      r_state   <= ST_IDLE;
      r_w       <= 3'b000;
      r_start_q <= 1'b1;
      r_cyc_cnt <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nx;
      r_w       <= w_w_nx;
      r_start_q <= START;
      if (r_state == ST_RUN && w_cyc_end) begin
        r_cyc_cnt <= r_cyc_cnt + 8'd1;
      end
    end
  end

  assign W       = r_w;
  assign RUN     = (r_state == ST_RUN);
  assign CYC_END = w_cyc_end;
  assign CYC_CNT = r_cyc_cnt;

endmodule
